// File: rtl/display_page_scheduler_if.sv
// Handshake bundle between the button/UART front end, the page scheduler and
// the segment decoder/loader.
//   Inputs to the scheduler:
//     btn_up, btn_left, btn_right  1-cycle pulses from the button edge detectors
//     auto_en                      level, 1 = auto-rotate pages
//     rx_done                      1-cycle pulse, UART byte received
//   Outputs from the scheduler:
//     page_sel      page shown: 00 TX[3:2], 01 TX[1:0], 10 RX[3:2], 11 RX[1:0]
//     page_changed  1-cycle pulse, the cycle after page_sel changes
//     memory_page   0 TX, 1 RX
//     current_page  LED indicator, page_sel[0] ? 01 : 10
//     scan_tick     1-cycle digit-scan pulse
//     digit_sel     digit being driven, 0..3
//     anode_n       active-low anode enables
interface display_page_scheduler_if;
  logic       btn_up;
  logic       btn_left;
  logic       btn_right;
  logic       auto_en;
  logic       rx_done;
  logic [1:0] page_sel;
  logic       page_changed;
  logic       memory_page;
  logic [1:0] current_page;
  logic       scan_tick;
  logic [1:0] digit_sel;
  logic [3:0] anode_n;

  modport master (
    output btn_up, btn_left, btn_right, auto_en, rx_done,
    input  page_sel, page_changed, memory_page, current_page,
           scan_tick, digit_sel, anode_n
  );

  modport slave (
    input  btn_up, btn_left, btn_right, auto_en, rx_done,
    output page_sel, page_changed, memory_page, current_page,
           scan_tick, digit_sel, anode_n
  );
endinterface

// File: rtl/display_page_scheduler.sv
// Page scheduler for the 4-digit seven-segment display. Picks which 16-bit
// page of the TX/RX byte buffers is shown (manual buttons, auto-rotation,
// received-data alert) and generates the digit-scan timebase.
//   clk    system clock
//   reset  synchronous, active low (0 = reset)
//   bus    display_page_scheduler_if.slave, see the interface for signals
module display_page_scheduler #(
  parameter int CLK_DIV    = 100000,
  parameter int AUTO_DWELL = 500,
  parameter int RX_HOLD    = 2000
) (
  input  logic                          clk,
  input  logic                          reset,
  display_page_scheduler_if.slave       bus
);

  localparam int PW = $clog2(CLK_DIV) + 1;
  localparam int DW = $clog2(AUTO_DWELL) + 1;
  localparam int HW = $clog2(RX_HOLD) + 1;

  localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DWELL_LIM = DW'(AUTO_DWELL);
  localparam logic [HW-1:0] HOLD_LIM  = HW'(RX_HOLD);

  typedef enum logic [1:0] {MANUAL, AUTO, ALERT} state_t;

  state_t        state, state_n;
  logic [1:0]    page, page_n;
  logic [1:0]    saved, saved_n;
  logic [DW-1:0] dwell, dwell_n;
  logic [HW-1:0] hold, hold_n;
  logic [PW-1:0] pre;
  logic [1:0]    digit;
  logic [1:0]    page_prev;
  logic          page_chg;

  logic          tick;
  logic          btn;
  logic [1:0]    btn_page;
  logic [DW-1:0] dwell_inc;
  logic [HW-1:0] hold_inc;

  assign tick      = (pre == PRE_MAX);
  assign btn       = bus.btn_up | bus.btn_left | bus.btn_right;
  assign dwell_inc = dwell + 1'b1;
  assign hold_inc  = hold + 1'b1;

  // up outranks left/right; lower-priority pulses in the same cycle are dropped
  always_comb begin
    btn_page = page;
    if (bus.btn_up)                       btn_page = {~page[1], 1'b0};
    else if (bus.btn_left | bus.btn_right) btn_page = {page[1], ~page[0]};
  end

  always_comb begin
    state_n = state;
    page_n  = page;
    saved_n = saved;
    dwell_n = dwell;
    hold_n  = hold;
    unique case (state)
      MANUAL, AUTO: begin
        if (bus.rx_done) begin
          // alert wins over buttons and dwell expiry
          saved_n = page;
          page_n  = 2'b11;
          hold_n  = '0;
          state_n = ALERT;
        end else if (state == MANUAL) begin
          if (btn) page_n = btn_page;
          if (bus.auto_en) begin
            state_n = AUTO;
            dwell_n = '0;
          end
        end else begin
          if (btn) begin
            page_n  = btn_page;
            dwell_n = '0;
          end else if (tick) begin
            if (dwell_inc == DWELL_LIM) begin
              page_n  = page + 2'd1;
              dwell_n = '0;
            end else begin
              dwell_n = dwell_inc;
            end
          end
          if (!bus.auto_en) state_n = MANUAL;
        end
      end
      ALERT: begin
        if (bus.rx_done) begin
          hold_n = '0;
        end else if (btn) begin
          page_n  = btn_page;
          dwell_n = '0;
          state_n = bus.auto_en ? AUTO : MANUAL;
        end else if (tick) begin
          if (hold_inc == HOLD_LIM) begin
            page_n  = saved;
            dwell_n = '0;
            state_n = bus.auto_en ? AUTO : MANUAL;
          end else begin
            hold_n = hold_inc;
          end
        end
      end
      default: state_n = MANUAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= MANUAL;
      page      <= 2'b00;
      saved     <= 2'b00;
      dwell     <= '0;
      hold      <= '0;
      pre       <= '0;
      digit     <= 2'd0;
      page_prev <= 2'b00;
      page_chg  <= 1'b0;
    end else begin
      state     <= state_n;
      page      <= page_n;
      saved     <= saved_n;
      dwell     <= dwell_n;
      hold      <= hold_n;
      pre       <= tick ? '0 : pre + 1'b1;
      if (tick) digit <= digit + 2'd1;
      // compare against last cycle's page so the pulse lands one cycle after the change
      page_prev <= page;
      page_chg  <= (page != page_prev);
    end
  end

  assign bus.page_sel     = page;
  assign bus.page_changed = page_chg;
  assign bus.memory_page  = page[1];
  assign bus.current_page = page[0] ? 2'b01 : 2'b10;
  assign bus.scan_tick    = tick;
  assign bus.digit_sel    = digit;
  assign bus.anode_n      = ~(4'b0001 << digit);

endmodule

// File: tb/tb_display_page_scheduler.sv
module tb_display_page_scheduler;
  logic clk;
  logic reset;
  int   nchk;
  int   nerr;

  display_page_scheduler_if bus();

  display_page_scheduler #(.CLK_DIV(4), .AUTO_DWELL(3), .RX_HOLD(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // consume n scan_ticks: each wait ends just after the tick edge
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int b;
      b = 0;
      while (!bus.scan_tick && b < 20) begin
        step();
        b++;
      end
      if (b >= 20) chk("tick_timeout", 32'd1, 32'd0);
      step();
    end
  endtask

  task automatic press(input logic u, input logic l, input logic r, input logic [1:0] exp, input string tag);
    bus.btn_up = u; bus.btn_left = l; bus.btn_right = r;
    step();
    bus.btn_up = 1'b0; bus.btn_left = 1'b0; bus.btn_right = 1'b0;
    chk({tag, "_page"}, bus.page_sel, exp);
    chk({tag, "_mem"}, bus.memory_page, exp[1]);
    chk({tag, "_cur"}, bus.current_page, exp[0] ? 2'b01 : 2'b10);
    chk({tag, "_pc0"}, bus.page_changed, 1'b0);
    step();
    chk({tag, "_pc1"}, bus.page_changed, 1'b1);
    step();
    chk({tag, "_pc2"}, bus.page_changed, 1'b0);
  endtask

  task automatic rx_pulse();
    bus.rx_done = 1'b1;
    step();
    bus.rx_done = 1'b0;
  endtask

  logic [3:0] an_exp [5];

  initial begin
    nchk = 0; nerr = 0;
    an_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    reset = 1'b0;
    bus.btn_up = 1'b0; bus.btn_left = 1'b0; bus.btn_right = 1'b0;
    bus.auto_en = 1'b0; bus.rx_done = 1'b0;

    // 1. reset and scan timebase
    repeat (3) step();
    chk("rst_page", bus.page_sel, 2'b00);
    chk("rst_anode", bus.anode_n, 4'b1110);
    chk("rst_tick", bus.scan_tick, 1'b0);
    chk("rst_digit", bus.digit_sel, 2'd0);
    chk("rst_pc", bus.page_changed, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      repeat (3) step();
      chk("scan_tick_hi", bus.scan_tick, 1'b1);
      chk("scan_anode_hold", bus.anode_n, an_exp[i]);
      step();
      chk("scan_tick_lo", bus.scan_tick, 1'b0);
      chk("scan_anode_next", bus.anode_n, an_exp[i+1]);
    end

    // 2. manual buttons
    press(1'b0, 1'b1, 1'b0, 2'b01, "man_left");
    press(1'b1, 1'b0, 1'b0, 2'b10, "man_up");
    press(1'b0, 1'b0, 1'b1, 2'b11, "man_right");
    press(1'b1, 1'b0, 1'b0, 2'b00, "man_up_wrap");

    // 3. up outranks left
    press(1'b0, 1'b1, 1'b0, 2'b01, "pri_setup");
    press(1'b1, 1'b1, 1'b0, 2'b10, "pri_up_left");
    press(1'b1, 1'b0, 1'b0, 2'b00, "pri_back");

    // 4. auto rotation
    bus.auto_en = 1'b1;
    step();
    wait_ticks(2);
    chk("auto_dwell2", bus.page_sel, 2'b00);
    wait_ticks(1);
    chk("auto_01", bus.page_sel, 2'b01);
    wait_ticks(3);
    chk("auto_10", bus.page_sel, 2'b10);
    wait_ticks(3);
    chk("auto_11", bus.page_sel, 2'b11);
    wait_ticks(3);
    chk("auto_wrap", bus.page_sel, 2'b00);
    wait_ticks(1);
    press(1'b0, 1'b1, 1'b0, 2'b01, "auto_left");
    wait_ticks(2);
    chk("auto_restart", bus.page_sel, 2'b01);
    wait_ticks(1);
    chk("auto_after_restart", bus.page_sel, 2'b10);

    // 5. rx alert with hold restart
    bus.auto_en = 1'b0;
    step();
    press(1'b1, 1'b0, 1'b0, 2'b00, "al_up");
    press(1'b0, 1'b1, 1'b0, 2'b01, "al_left");
    rx_pulse();
    chk("alert_page", bus.page_sel, 2'b11);
    chk("alert_mem", bus.memory_page, 1'b1);
    wait_ticks(3);
    rx_pulse();
    chk("alert_rx2", bus.page_sel, 2'b11);
    wait_ticks(4);
    chk("alert_hold4", bus.page_sel, 2'b11);
    wait_ticks(1);
    chk("alert_restore", bus.page_sel, 2'b01);
    step();
    chk("alert_restore_pc", bus.page_changed, 1'b1);

    // 6. reset during alert drops the pending restore
    rx_pulse();
    chk("alert2_page", bus.page_sel, 2'b11);
    reset = 1'b0;
    step();
    chk("midrst_page", bus.page_sel, 2'b00);
    chk("midrst_anode", bus.anode_n, 4'b1110);
    reset = 1'b1;
    wait_ticks(6);
    chk("midrst_norestore", bus.page_sel, 2'b00);

    // button in alert applies to page 11 and discards saved
    press(1'b0, 1'b1, 1'b0, 2'b01, "btnal_setup");
    rx_pulse();
    chk("btnal_alert", bus.page_sel, 2'b11);
    step();
    press(1'b1, 1'b0, 1'b0, 2'b00, "btnal_up");
    wait_ticks(6);
    chk("btnal_norestore", bus.page_sel, 2'b00);

    // restore to 11 from 11 raises no page_changed
    press(1'b1, 1'b0, 1'b0, 2'b10, "r11_up");
    press(1'b0, 1'b1, 1'b0, 2'b11, "r11_left");
    rx_pulse();
    wait_ticks(5);
    chk("r11_page", bus.page_sel, 2'b11);
    step();
    chk("r11_nopc", bus.page_changed, 1'b0);
    press(1'b1, 1'b0, 1'b0, 2'b00, "r11_exit");

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
